// File: rtl/branch_update_unit.sv
// branch_update_unit: write-side companion of the branch target buffer.
// Queues resolved branches in a small FIFO, then for each one reads the
// current BTB frame, updates the 2-bit counter and target, and writes it back.
// Flags mispredictions and supplies the redirect PC to fetch.
// Optional macro BRANCH_UPDATE_STATS_EN adds branch/mispredict counters.
module branch_update_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic             res_ready,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [IDX_W-1:0] btb_rsel,
  input  logic [33:0]      btb_rdat,
  output logic             btb_wen,
  output logic [IDX_W-1:0] btb_wsel,
  output logic [33:0]      btb_wdat,
  output logic             busy
`ifdef BRANCH_UPDATE_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_e;

  // Only the BTB index bits of the PC are ever needed after the push.
  logic [IDX_W-1:0] fifo_idx_q [DEPTH];
  logic             fifo_taken_q [DEPTH];
  logic [31:0]      fifo_target_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q, state_d;
  logic [1:0]       old_state_q, old_state_d;
  logic [31:0]      old_target_q, old_target_d;
  logic [IDX_W-1:0] rsel_q, rsel_d, wsel_q, wsel_d;
  logic [33:0]      wdat_q, wdat_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_q, redirect_d;

  logic             push, pop, wen_raw;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [31:0]      head_target;
  logic [1:0]       new_state;

  // FIFO handshake, occupancy and misprediction detection
  always_comb begin
    res_ready    = (count_q != CNT_FULL);
    push         = res_valid && res_ready;
    pop          = (state_q == WRITE);
    head_d       = pop  ? head_q + PTR_ONE : head_q;
    tail_d       = push ? tail_q + PTR_ONE : tail_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
    mispredict_d = push && ((res_taken != res_pred_taken) ||
                            (res_taken && (res_target != res_pred_target)));
    redirect_d   = '0;
    if (mispredict_d) redirect_d = res_taken ? res_target : res_pc + 32'd4;
  end

  // Head entry fields and the saturating counter / target update
  always_comb begin
    head_idx    = fifo_idx_q[head_q];
    head_taken  = fifo_taken_q[head_q];
    head_target = fifo_target_q[head_q];
    if (head_taken) new_state = (old_state_q == 2'd3) ? 2'd3 : old_state_q + 2'd1;
    else            new_state = (old_state_q == 2'd0) ? 2'd0 : old_state_q - 2'd1;
  end

  // FSM next state and BTB port drive; index/data outputs hold outside their phase
  always_comb begin
    state_d      = state_q;
    old_state_d  = old_state_q;
    old_target_d = old_target_q;
    rsel_d       = rsel_q;
    wsel_d       = wsel_q;
    wdat_d       = wdat_q;
    wen_raw      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOOKUP;
      end
      LOOKUP: begin
        rsel_d       = head_idx;
        old_state_d  = btb_rdat[33:32];
        old_target_d = btb_rdat[31:0];
        state_d      = WRITE;
      end
      WRITE: begin
        wen_raw = 1'b1;
        wsel_d  = head_idx;
        wdat_d  = {new_state, head_taken ? head_target : old_target_q};
        state_d = (count_d != '0) ? LOOKUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    btb_rsel = rsel_d;
    btb_wsel = wsel_d;
    btb_wdat = wdat_d;
    btb_wen  = wen_raw && !RST;
  end

  // Control and status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      old_state_q  <= '0;
      old_target_q <= '0;
      rsel_q       <= '0;
      wsel_q       <= '0;
      wdat_q       <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      old_state_q  <= old_state_d;
      old_target_q <= old_target_d;
      rsel_q       <= rsel_d;
      wsel_q       <= wsel_d;
      wdat_q       <= wdat_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  // FIFO storage write on push
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_idx_q[tail_q]    <= res_pc[IDX_W+1:2];
      fifo_taken_q[tail_q]  <= res_taken;
      fifo_target_q[tail_q] <= res_target;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);

`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

  // Branch and mispredict counters, wrapping naturally
  always_comb begin
    stat_br_d  = push ? stat_br_q + 32'd1 : stat_br_q;
    stat_mis_d = mispredict_d ? stat_mis_q + 32'd1 : stat_mis_q;
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// tb_branch_update_unit: directed, table-driven bench for branch_update_unit
// with a negedge-written BTB model.
module tb_branch_update_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = '0;
  logic        res_ready, mispredict, btb_wen, busy;
  logic [31:0] redirect_pc;
  logic [7:0]  btb_rsel, btb_wsel;
  logic [33:0] btb_rdat, btb_wdat;
`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_update_unit #(.DEPTH(4), .IDX_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .res_ready(res_ready),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .btb_rsel(btb_rsel), .btb_rdat(btb_rdat), .btb_wen(btb_wen),
    .btb_wsel(btb_wsel), .btb_wdat(btb_wdat), .busy(busy)
`ifdef BRANCH_UPDATE_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  logic [33:0] btb_mem [256];
  logic [7:0]  log_idx [$];
  logic [33:0] log_dat [$];

  assign btb_rdat = btb_mem[btb_rsel];

  always @(negedge CLK) begin
    if (btb_wen) begin
      btb_mem[btb_wsel] = btb_wdat;
      log_idx.push_back(btb_wsel);
      log_dat.push_back(btb_wdat);
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                          input logic pt, input logic [31:0] ptg);
    res_pc = pc; res_taken = tk; res_target = tg;
    res_pred_taken = pt; res_pred_target = ptg; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        pt;
    logic [31:0] ptgt;
    logic [33:0] init;
    logic [7:0]  exp_idx;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic [33:0] exp_wdat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int unsigned cnt;
    int unsigned acc;
    int unsigned k;
    logic seen_full;
    logic found;

    for (int i = 0; i < 256; i++) btb_mem[i] = '0;

    vecs[0] = '{32'h40, 1'b1, 32'h100, 1'b0, 32'h0,   {2'd0, 32'h0},   8'h10, 1'b1, 32'h100, {2'd1, 32'h100}};
    vecs[1] = '{32'h44, 1'b0, 32'h0,   1'b0, 32'h0,   {2'd3, 32'h200}, 8'h11, 1'b0, 32'h0,   {2'd2, 32'h200}};
    vecs[2] = '{32'h48, 1'b1, 32'h300, 1'b1, 32'h300, {2'd3, 32'h300}, 8'h12, 1'b0, 32'h0,   {2'd3, 32'h300}};
    vecs[3] = '{32'h4C, 1'b0, 32'h0,   1'b0, 32'h0,   {2'd0, 32'h0},   8'h13, 1'b0, 32'h0,   {2'd0, 32'h0}};
    vecs[4] = '{32'h50, 1'b1, 32'h500, 1'b1, 32'h600, {2'd2, 32'h600}, 8'h14, 1'b1, 32'h500, {2'd3, 32'h500}};
    vecs[5] = '{32'h54, 1'b0, 32'h700, 1'b1, 32'h700, {2'd2, 32'h700}, 8'h15, 1'b1, 32'h58,  {2'd1, 32'h700}};
    vecs[6] = '{32'h3FC, 1'b0, 32'h123, 1'b0, 32'h999, {2'd1, 32'hABC}, 8'hFF, 1'b0, 32'h0,  {2'd0, 32'hABC}};
    vecs[7] = '{32'h12345408, 1'b1, 32'h20, 1'b1, 32'h20, {2'd1, 32'h10}, 8'h02, 1'b0, 32'h0, {2'd2, 32'h20}};

    // Reset held two cycles with res_valid high
    RST = 1'b1; res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1;
    tick(); tick();
    chk("rst_ready", res_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wen", btb_wen, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_wsel", btb_wsel, 0);
    chk("rst_wdat", btb_wdat, 0);
    RST = 1'b0; res_valid = 1'b0;
    tick();
    chk("rst_no_enq_busy", busy, 0);
    tick();
    chk("rst_no_enq_wen", btb_wen, 0);

    // Reset asserted during a WRITE cycle
    push_one(32'h60, 1'b1, 32'h600, 1'b1, 32'h600);
    push_one(32'h64, 1'b1, 32'h640, 1'b1, 32'h640);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (btb_wen) found = 1'b1;
      else tick();
    end
    chk("rstw_reach_write", found, 1);
    log_idx.delete(); log_dat.delete();
    RST = 1'b1;
    #1;
    chk("rstw_wen_forced", btb_wen, 0);
    tick();
    RST = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_ready", res_ready, 1);
    chk("rstw_rsel", btb_rsel, 0);
    chk("rstw_wsel", btb_wsel, 0);
    for (int c = 0; c < 6; c++) tick();
    chk("rstw_no_writes", log_idx.size(), 0);

    // Single-branch vectors
    foreach (vecs[i]) begin
      btb_mem[vecs[i].exp_idx] = vecs[i].init;
      push_one(vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].pt, vecs[i].ptgt);
      chk($sformatf("v%0d_mis", i), mispredict, vecs[i].exp_mis);
      chk($sformatf("v%0d_redir", i), redirect_pc, vecs[i].exp_redir);
      tick();
      chk($sformatf("v%0d_mis_clr", i), mispredict, 0);
      chk($sformatf("v%0d_wen_early", i), btb_wen, 0);
      tick();
      chk($sformatf("v%0d_wen", i), btb_wen, 1);
      chk($sformatf("v%0d_wsel", i), btb_wsel, vecs[i].exp_idx);
      chk($sformatf("v%0d_wdat", i), btb_wdat, vecs[i].exp_wdat);
      tick();
      chk($sformatf("v%0d_wen_off", i), btb_wen, 0);
      chk($sformatf("v%0d_wdat_hold", i), btb_wdat, vecs[i].exp_wdat);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Back-to-back updates to the same index
    btb_mem[8'h10] = '0;
    log_idx.delete(); log_dat.delete();
    push_one(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    push_one(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("b2b_drained", busy, 0);
    chk("b2b_count", log_idx.size(), 2);
    if (log_idx.size() == 2) begin
      chk("b2b_idx0", log_idx[0], 8'h10);
      chk("b2b_dat0", log_dat[0], {2'd1, 32'h100});
      chk("b2b_idx1", log_idx[1], 8'h10);
      chk("b2b_dat1", log_dat[1], {2'd2, 32'h100});
    end

    // Back-pressure: six consecutive pushes into a 4-deep FIFO
    log_idx.delete(); log_dat.delete();
    for (int i = 0; i < 6; i++) btb_mem[8'h20 + i] = '0;
    cnt = 0; k = 0; seen_full = 1'b0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      res_pc = 32'h80 + 4 * k; res_taken = 1'b1; res_target = 32'h1000 + 16 * k;
      res_pred_taken = 1'b1; res_pred_target = 32'h1000 + 16 * k; res_valid = 1'b1;
      chk($sformatf("bp_ready_c%0d", c), res_ready, (cnt != 4));
      if (!res_ready) seen_full = 1'b1;
      acc = res_ready ? 1 : 0;
      cnt = cnt + acc - (btb_wen ? 1 : 0);
      tick();
      k = k + acc;
    end
    res_valid = 1'b0;
    chk("bp_all_pushed", k, 6);
    chk("bp_saw_full", seen_full, 1);
    for (int c = 0; c < 30 && busy; c++) tick();
    chk("bp_drained", busy, 0);
    chk("bp_count", log_idx.size(), 6);
    if (log_idx.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("bp_idx%0d", i), log_idx[i], 8'h20 + i);
        chk($sformatf("bp_dat%0d", i), log_dat[i], {2'd1, 32'h1000 + 16 * i});
      end
    end

`ifdef BRANCH_UPDATE_STATS_EN
    chk("stat_branches", stat_branches, 16);
    chk("stat_mispredicts", stat_mispredicts, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
